// File: rtl/seg7_scan_ndigit_if.sv
// seg7_scan_ndigit_if
//   Bundles the digit-data inputs and the display-pin outputs of the
//   multiplexed 7-segment scanner.
//   master : producer of display data, consumer of the pin outputs
//   slave  : the scanner itself
//   Signals:
//     digits_in  [4*DIGITS]  packed nibbles, digit 0 rightmost
//     dp_in      [DIGITS]    decimal point request, 1 = lit
//     blank_in   [DIGITS]    force digit dark, 1 = blank
//     lz_en                  leading-zero suppression enable
//     update                 capture strobe for the four inputs above
//     seg        [7]         {a..g}, seg[6]=a, active-low
//     dp                     decimal point, active-low
//     an         [DIGITS]    digit enables, active-low one-hot-cold
//     frame_done             one-cycle pulse after each full scan
interface seg7_scan_ndigit_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] digits_in;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   blank_in;
  logic                lz_en;
  logic                update;
  logic [6:0]          seg;
  logic                dp;
  logic [DIGITS-1:0]   an;
  logic                frame_done;

  modport master (
    output digits_in, dp_in, blank_in, lz_en, update,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  digits_in, dp_in, blank_in, lz_en, update,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/seg7_scan_ndigit.sv
// seg7_scan_ndigit
//   Time-multiplexed N-digit common-anode 7-segment driver. Input data is
//   captured into a staging register on `update` and promoted to the display
//   register only at frame boundaries, so a scan never shows mixed data.
//   Each digit slot starts with BLANK_CYCLES of all-anodes-off to avoid
//   ghosting. All pin outputs are registered (one cycle behind scan state).
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous, active-high
//     bus    seg7_scan_ndigit_if.slave (data in, display pins out)
module seg7_scan_ndigit #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               reset,
  seg7_scan_ndigit_if.slave  bus
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_C  = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_idx;

  logic [4*DIGITS-1:0] r_stg_dig;
  logic [DIGITS-1:0]   r_stg_dp;
  logic [DIGITS-1:0]   r_stg_blank;
  logic                r_stg_lz;

  logic [4*DIGITS-1:0] r_dsp_dig;
  logic [DIGITS-1:0]   r_dsp_dp;
  logic [DIGITS-1:0]   r_dsp_blank;
  logic                r_dsp_lz;

  logic                w_slot_end;
  logic                w_frame_end;
  logic                w_blank_ph;
  logic [DIGITS-1:0]   w_sup;
  logic                w_run;
  logic [3:0]          w_nib;
  logic                w_dark;
  logic [6:0]          w_dec;
  logic [DIGITS-1:0]   w_an;

  function automatic logic [6:0] f_decode(input logic [3:0] v);
    case (v)
      4'h0: f_decode = 7'b0000001;
      4'h1: f_decode = 7'b1001111;
      4'h2: f_decode = 7'b0010010;
      4'h3: f_decode = 7'b0000110;
      4'h4: f_decode = 7'b1001100;
      4'h5: f_decode = 7'b0100100;
      4'h6: f_decode = 7'b0100000;
      4'h7: f_decode = 7'b0001111;
      4'h8: f_decode = 7'b0000000;
      4'h9: f_decode = 7'b0000100;
      4'hA: f_decode = 7'b0001000;
      4'hB: f_decode = 7'b1100000;
      4'hC: f_decode = 7'b0110001;
      4'hD: f_decode = 7'b1000010;
      4'hE: f_decode = 7'b0110000;
      default: f_decode = 7'b0111000;
    endcase
  endfunction

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);
  assign w_blank_ph  = (r_cnt < BLANK_C);

  // Walk from the most significant digit down; suppression stays active
  // only while every digit seen so far is zero or blanked. Digit 0 is exempt.
  always_comb begin
    w_run = r_dsp_lz;
    w_sup = '0;
    for (int unsigned i = DIGITS; i > 0; i--) begin
      w_run = w_run & ((r_dsp_dig[4*(i-1) +: 4] == 4'h0) | r_dsp_blank[i-1]);
      if (i > 1) w_sup[i-1] = w_run;
    end
  end

  always_comb begin
    w_nib      = r_dsp_dig[{r_idx, 2'b00} +: 4];
    w_dark     = w_sup[r_idx] | r_dsp_blank[r_idx];
    w_dec      = f_decode(w_nib);
    w_an       = '1;
    w_an[r_idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt          <= '0;
      r_idx          <= '0;
      r_stg_dig      <= '0;
      r_stg_dp       <= '0;
      r_stg_blank    <= '0;
      r_stg_lz       <= 1'b0;
      r_dsp_dig      <= '0;
      r_dsp_dp       <= '0;
      r_dsp_blank    <= '0;
      r_dsp_lz       <= 1'b0;
      bus.seg        <= 7'h7F;
      bus.dp         <= 1'b1;
      bus.an         <= '1;
      bus.frame_done <= 1'b0;
    end else begin
      if (w_slot_end) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (bus.update) begin
        r_stg_dig   <= bus.digits_in;
        r_stg_dp    <= bus.dp_in;
        r_stg_blank <= bus.blank_in;
        r_stg_lz    <= bus.lz_en;
      end

      // A strobe coinciding with the boundary bypasses staging so the new
      // frame already shows it.
      if (w_frame_end) begin
        r_dsp_dig   <= bus.update ? bus.digits_in : r_stg_dig;
        r_dsp_dp    <= bus.update ? bus.dp_in     : r_stg_dp;
        r_dsp_blank <= bus.update ? bus.blank_in  : r_stg_blank;
        r_dsp_lz    <= bus.update ? bus.lz_en     : r_stg_lz;
      end

      bus.frame_done <= w_frame_end;

      if (w_blank_ph) begin
        bus.an  <= '1;
        bus.seg <= 7'h7F;
        bus.dp  <= 1'b1;
      end else begin
        bus.an  <= w_an;
        bus.seg <= w_dark ? 7'h7F : w_dec;
        // Suppressed digits keep their decimal point; blanked ones do not.
        bus.dp  <= r_dsp_blank[r_idx] | ~r_dsp_dp[r_idx];
      end
    end
  end

endmodule
